// File: rtl/seq_det_sched_if.sv
// Handshake and hit-reporting bundle between the serial front-end streams
// and the time-shared pattern detector.
interface seq_det_sched_if #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
);
    logic [N-1:0]   req_vld;
    logic [N-1:0]   req_din;
    logic [N-1:0]   req_rdy;
    logic [N-1:0]   ctx_clr;
    logic           hit;
    logic [IDW-1:0] hit_id;
    logic           busy;
    logic [IDW-1:0] gnt_id;

    modport master (
        output req_vld, req_din, ctx_clr,
        input  req_rdy, hit, hit_id, busy, gnt_id
    );

    modport slave (
        input  req_vld, req_din, ctx_clr,
        output req_rdy, hit, hit_id, busy, gnt_id
    );
endinterface

// File: rtl/seq_det_sched.sv
// One serial 6-bit pattern detector shared round-robin between N streams, with
// per-stream 5-bit history saved on release and restored on grant.
module seq_det_sched #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDW   = 2,
    parameter int unsigned BURST = 8,
    parameter logic [5:0]  PAT0  = 6'b111000,
    parameter logic [5:0]  PAT1  = 6'b101110
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_det_sched_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StSave} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [IDW-1:0] hit_id_q, hit_id_d;
    logic           hit_q, hit_d;
    logic [4:0]     hist_q, hist_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [4:0]     ctx_q [N];
    logic [4:0]     ctx_d [N];

    logic           found;
    logic [IDW-1:0] sel;
    int unsigned    idx;

    // Round-robin scan starting at rr_ptr; wraps at N, not at 2**IDW.
    always_comb begin
        found = 1'b0;
        sel   = rr_ptr_q;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && bus.req_vld[IDW'(idx)]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end
    end

    logic       clr_live;
    logic [4:0] hist_src;
    logic [5:0] win;
    logic       match;
    logic [7:0] cnt_inc;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_id_d = gnt_id_q;
        hit_id_d = hit_id_q;
        hit_d    = 1'b0;
        hist_d   = hist_q;
        cnt_d    = cnt_q;
        ctx_d    = ctx_q;
        cnt_inc  = cnt_q + 8'd1;

        // A clear of the granted stream also wipes the live copy, so a bit
        // accepted in the same cycle sees an all-zero history.
        clr_live = bus.ctx_clr[gnt_id_q] && (state_q == StLoad || state_q == StRun);
        hist_src = clr_live ? 5'b0 : hist_q;
        win      = {hist_src, bus.req_din[gnt_id_q]};
        match    = (win == PAT0) || (win == PAT1);

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_id_d = sel;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                hist_d  = clr_live ? 5'b0 : ctx_q[gnt_id_q];
                cnt_d   = 8'd0;
                state_d = StRun;
            end
            StRun: begin
                if (bus.req_vld[gnt_id_q]) begin
                    hist_d = win[4:0];
                    cnt_d  = cnt_inc;
                    hit_d  = match;
                    if (match) hit_id_d = gnt_id_q;
                    if (cnt_inc == 8'(BURST)) state_d = StSave;
                end else begin
                    hist_d  = hist_src;
                    state_d = StSave;
                end
            end
            StSave: begin
                ctx_d[gnt_id_q] = hist_q;
                rr_ptr_d        = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + 1'b1;
                state_d         = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Clear wins over a same-cycle save of the same stream.
        for (int unsigned i = 0; i < N; i++) begin
            if (bus.ctx_clr[i]) ctx_d[i] = 5'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            gnt_id_q <= '0;
            hit_id_q <= '0;
            hit_q    <= 1'b0;
            hist_q   <= 5'b0;
            cnt_q    <= 8'd0;
            for (int unsigned i = 0; i < N; i++) ctx_q[i] <= 5'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_id_q <= gnt_id_d;
            hit_id_q <= hit_id_d;
            hit_q    <= hit_d;
            hist_q   <= hist_d;
            cnt_q    <= cnt_d;
            ctx_q    <= ctx_d;
        end
    end

    always_comb begin
        bus.req_rdy = '0;
        if (state_q == StRun) bus.req_rdy[gnt_id_q] = 1'b1;
    end

    assign bus.busy   = (state_q != StIdle);
    assign bus.gnt_id = gnt_id_q;
    assign bus.hit    = hit_q;
    assign bus.hit_id = hit_id_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// Scoreboard bench: a private 6-bit detector per stream predicts every hit;
// grant order and burst lengths are logged from the req_rdy handshake.
module tb_seq_det_sched;
    localparam int unsigned N     = 4;
    localparam int unsigned IDW   = 2;
    localparam int unsigned BURST = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    seq_det_sched_if #(.N(N), .IDW(IDW)) bus ();

    seq_det_sched #(
        .N    (N),
        .IDW  (IDW),
        .BURST(BURST),
        .PAT0 (6'b111000),
        .PAT1 (6'b101110)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic           hit;
        logic [IDW-1:0] id;
    } exp_t;

    exp_t           sb[$];
    int             n_vec = 0;
    int             n_bad = 0;
    logic           bits [N][64];
    int             len  [N];
    int             pos  [N];
    logic [N-1:0]   en;
    logic [N-1:0]   clr_req;
    logic [4:0]     mhist [N];
    logic [IDW-1:0] last_id;
    logic [N-1:0]   prev_rdy;
    int             glog[$];
    int             clog[$];
    int             cur_cnt;
    int             hit_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Append n bits of v, most significant first.
    task automatic send(input int s, input logic [15:0] v, input int n);
        logic [15:0] sh;
        sh = v << (16 - n);
        for (int k = 0; k < n; k++) begin
            bits[s][len[s]] = sh[15];
            sh = sh << 1;
            len[s]++;
        end
    endtask

    task automatic step();
        exp_t         e;
        logic [N-1:0] rdy;
        logic [N-1:0] vld;
        logic [N-1:0] din;
        logic [5:0]   w;
        @(negedge clk);
        if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        check("hit", 32'(bus.hit), 32'(e.hit));
        if (e.hit) last_id = e.id;
        check("hit_id", 32'(bus.hit_id), 32'(last_id));
        if (bus.hit) hit_cnt++;
        rdy = bus.req_rdy;
        check("rdy_onehot0", 32'($onehot0(rdy)), 1);
        if (rdy != 0 && prev_rdy == 0) begin
            glog.push_back(int'(bus.gnt_id));
            cur_cnt = 0;
        end
        if (rdy == 0 && prev_rdy != 0) clog.push_back(cur_cnt);
        prev_rdy = rdy;

        e = '0;
        for (int i = 0; i < N; i++) begin
            vld[i] = en[i] && (pos[i] < len[i]);
            din[i] = vld[i] ? bits[i][pos[i]] : 1'b0;
        end
        bus.req_vld = vld;
        bus.req_din = din;
        bus.ctx_clr = clr_req;
        for (int i = 0; i < N; i++) begin
            if (clr_req[i]) mhist[i] = 5'b0;
            if (vld[i] && rdy[i]) begin
                w = {mhist[i], din[i]};
                if (w == 6'b111000 || w == 6'b101110) begin
                    e.hit = 1'b1;
                    e.id  = IDW'(i);
                end
                mhist[i] = w[4:0];
                pos[i]++;
                cur_cnt++;
            end
        end
        clr_req = '0;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.req_vld = '0;
        bus.req_din = '0;
        bus.ctx_clr = '0;
        en          = '0;
        clr_req     = '0;
        for (int i = 0; i < N; i++) begin
            len[i]   = 0;
            pos[i]   = 0;
            mhist[i] = 5'b0;
        end
        sb.delete();
        glog.delete();
        clog.delete();
        last_id  = '0;
        prev_rdy = '0;
        cur_cnt  = 0;
        hit_cnt  = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('0);
    endtask

    task automatic run_all();
        int  g;
        logic pend;
        g    = 0;
        pend = 1'b1;
        while (pend && g < 400) begin
            step();
            g++;
            pend = 1'b0;
            for (int i = 0; i < N; i++) if (en[i] && pos[i] < len[i]) pend = 1'b1;
        end
        if (pend) check("run_timeout", 1, 0);
        repeat (4) step();
    endtask

    task automatic check_log(input string tag, input int q[$], input int k, input int exp);
        check(tag, (k < q.size()) ? q[k] : -1, exp);
    endtask

    initial begin
        bus.req_vld = '0;
        bus.req_din = '0;
        bus.ctx_clr = '0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_rdy", 32'(bus.req_rdy), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_hit", 32'(bus.hit), 0);
        check("rst_gnt", 32'(bus.gnt_id), 0);
        check("rst_hit_id", 32'(bus.hit_id), 0);

        // Single stream 111000
        do_reset();
        send(0, 16'b111000, 6);
        en = 4'b0001;
        begin
            int g = 0;
            while (pos[0] < len[0] && g < 100) begin
                step();
                g++;
            end
        end
        step();
        step();
        check("busy_save", 32'(bus.busy), 1);
        step();
        check("busy_idle", 32'(bus.busy), 0);
        repeat (3) step();
        check("t1_hits", hit_cnt, 1);

        // Context preserved across switches
        do_reset();
        send(0, 16'b101110, 6);
        send(1, 16'b000000, 6);
        en = 4'b0011;
        run_all();
        check_log("t2_gnt0", glog, 0, 0);
        check_log("t2_gnt1", glog, 1, 1);
        check_log("t2_gnt2", glog, 2, 0);
        check_log("t2_cnt0", clog, 0, 4);
        check_log("t2_cnt1", clog, 1, 4);
        check_log("t2_cnt2", clog, 2, 2);
        check("t2_hits", hit_cnt, 1);

        // Round-robin fairness, all streams busy
        do_reset();
        for (int i = 0; i < N; i++) send(i, 16'($urandom_range(0, 4095)), 12);
        en = 4'b1111;
        repeat (40) step();
        check("t3_ngnt", 32'(glog.size() >= 5), 1);
        for (int k = 0; k < glog.size(); k++) check("t3_gnt", glog[k], k % N);
        for (int k = 0; k < clog.size(); k++) check("t3_cnt", clog[k], BURST);

        // Early end of burst on stream 2
        do_reset();
        send(2, 16'b111, 3);
        send(3, 16'b0101, 4);
        send(0, 16'b1100, 4);
        en = 4'b0100;
        run_all();
        check_log("t4_gnt0", glog, 0, 2);
        check_log("t4_cnt0", clog, 0, 3);
        check("t4_rr", 32'(dut.rr_ptr_q), 3);
        check("t4_ctx2", 32'(dut.ctx_q[2]), 32'h07);
        en = 4'b1101;
        run_all();
        check_log("t4_gnt1", glog, 1, 3);
        check_log("t4_gnt2", glog, 2, 0);
        send(2, 16'b000, 3);
        run_all();
        check_log("t4_gnt3", glog, 3, 2);
        check("t4_hits", hit_cnt, 1);

        // Context clear removes saved history
        do_reset();
        send(0, 16'b11100, 5);
        en = 4'b0001;
        run_all();
        clr_req = 4'b0001;
        step();
        step();
        check("t5_ctx0", 32'(dut.ctx_q[0]), 0);
        send(0, 16'b0, 1);
        run_all();
        check("t5_hits_clr", hit_cnt, 0);
        do_reset();
        send(0, 16'b11100, 5);
        en = 4'b0001;
        run_all();
        send(0, 16'b0, 1);
        run_all();
        check("t5_hits_noclr", hit_cnt, 1);

        // Asynchronous reset mid-burst
        do_reset();
        send(1, 16'b111000, 6);
        en = 4'b0010;
        begin
            int g = 0;
            while (pos[1] < 3 && g < 100) begin
                step();
                g++;
            end
        end
        check("t6_inrun", 32'(bus.req_rdy), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rdy", 32'(bus.req_rdy), 0);
        check("t6_busy", 32'(bus.busy), 0);
        check("t6_gnt", 32'(bus.gnt_id), 0);
        check("t6_hit", 32'(bus.hit), 0);
        check("t6_hit_id", 32'(bus.hit_id), 0);
        do_reset();
        send(1, 16'b1000111000, 10);
        en = 4'b0010;
        run_all();
        check("t6_hits", hit_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
